id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS pipeline. It sits directly downstream of the control-unit decoder. Each cycle it captures the decoder's control bundle together with the ID-stage operands and register indices, and presents them to EX one cycle later. It also detects load-use hazards, inserts bubbles, and applies branch/jump flushes and downstream holds.

## Interface
- DATA_W, 32, width of PC, register-data and immediate fields
- REG_W, 5, register index width
- CNT_W, 16, width of the bubble performance counter
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_jump  in  1 each  decoder control outputs
- id_alu_op  in  2  decoder ALU op class
- id_valid  in  1  ID slot holds a real instruction
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W  source/destination indices
- id_funct  in  6  funct field
- flush  in  1  squash the ID instruction (branch taken / jump)
- hold  in  1  downstream freeze; EX must not change
- ex_* (one per id_* input above, same width)  out  registered copies
- ex_valid  out  1  EX slot holds a real instruction
- stall  out  1  load-use hazard; freezes PC and IF/ID
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Hazard uses for the ID instruction:
  - uses_rs = ~id_jump.
  - uses_rt = id_reg_dst | id_mem_write | id_branch.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- stall = hazard & ~flush & ~rst. This signal is combinational.
- Register update priority at each rising edge, highest first:
  - rst: all ex_* outputs, ex_valid and bubble_count go to 0.
  - flush: load a bubble.
  - hold: retain every register, including bubble_count.
  - hazard: load a bubble and increment bubble_count.
  - otherwise: load all id_* fields into ex_*; ex_valid <= id_valid.
- Bubble: all control outputs (reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src, reg_dst, jump, alu_op) and ex_valid become 0. Data and index fields (pc4, rs_data, rt_data, imm, rs, rt, rd, funct) hold their previous values.
- If id_valid = 0 on a normal load, control fields are still loaded as presented. Downstream qualifies them with ex_valid.
- bubble_count saturates at all-ones and does not wrap. Only hazard bubbles count; flush bubbles do not.
- A load into $0 (ex_rt = 0) never causes a stall.

## Timing
- Latency: an id_* value present at edge N appears on ex_* after edge N. This is exactly one cycle.
- stall is asserted in the same cycle the hazard exists, with no registered delay. After the bubble loads, ex_mem_read = 0, so stall drops the next cycle. Each lw causes exactly one bubble.
- hold and hazard in the same cycle: hold wins, so there is no bubble and no count. stall stays asserted while hold is high.
- flush and hazard in the same cycle: the bubble loads, stall = 0 and the count is unchanged.
- rst asserted mid-stream: all outputs read 0 after that edge. stall is 0 while rst is high.

## Test plan
- Reset: assert rst for 2 cycles with arbitrary inputs -> all ex_*, ex_valid, bubble_count and stall read 0.
- Pass-through: R-type (reg_dst=1, reg_write=1, alu_op=10, rs=8, rt=9, rd=10, rs_data=0x11, rt_data=0x22) with no lw in EX -> after one edge, ex_* match the inputs exactly, ex_valid=1, stall=0.
- Load-use stall: lw $9 in EX, then ID holds add $10,$9,$8 -> stall=1 for exactly one cycle; next edge ex_valid=0, all controls 0, bubble_count=1; the following edge loads the add.
- No false hazard:
  - lw $0 then add $1,$0,$0 -> stall=0.
  - lw $9 then j (jump=1, id_rs=9) -> stall=0.
  - lw $9 then addi $9,$9,1 (rt not used, rs=9) -> stall=1.
- Priority: hazard with flush=1 -> bubble, stall=0, count unchanged. Hazard with hold=1 and no flush -> ex_* unchanged, stall=1, count unchanged.
- Saturation: force 0xFFFF+3 hazard bubbles -> bubble_count stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS pipeline.
// Detects load-use hazards and applies flush, hold and bubble insertion.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_jump,
    input  logic [1:0]        id_alu_op,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [5:0]        id_funct,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic              ex_jump,
    output logic [1:0]        ex_alu_op,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [5:0]        ex_funct,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       jump;
        logic [1:0] alu_op;
        logic       valid;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [5:0]        funct;
    } data_t;

    ctrl_t            ctrl_q, ctrl_d, ctrl_in;
    data_t            data_q, data_d, data_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uses_rs, uses_rt, hazard;

    assign ctrl_in = '{id_reg_write, id_mem_to_reg, id_branch,
                       id_mem_read, id_mem_write, id_alu_src,
                       id_reg_dst, id_jump, id_alu_op, id_valid};
    assign data_in = '{id_pc4, id_rs_data, id_rt_data, id_imm,
                       id_rs, id_rt, id_rd, id_funct};

    assign uses_rs = ~id_jump;
    assign uses_rt = id_reg_dst | id_mem_write | id_branch;

    assign hazard = id_valid & ctrl_q.valid & ctrl_q.mem_read
                  & (data_q.rt != '0)
                  & ((uses_rs & (data_q.rt == id_rs))
                   | (uses_rt & (data_q.rt == id_rt)));

    assign stall = hazard & ~flush & ~rst;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (hold) begin
            ctrl_d = ctrl_q;
        end else if (hazard) begin
            // Bubble clears only control; data fields keep old values
            ctrl_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
            ctrl_d = ctrl_in;
            data_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_jump       = ctrl_q.jump;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_valid      = ctrl_q.valid;
    assign ex_pc4        = data_q.pc4;
    assign ex_rs_data    = data_q.rs_data;
    assign ex_rt_data    = data_q.rt_data;
    assign ex_imm        = data_q.imm;
    assign ex_rs         = data_q.rs;
    assign ex_rt         = data_q.rt;
    assign ex_rd         = data_q.rd;
    assign ex_funct      = data_q.funct;
    assign bubble_count  = cnt_q;

endmodule
